// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared definitions for the stopwatch control/count path:
//   - state_t   : start/pause/clear FSM state encoding
//   - DIG_MAX_* : terminal values of the BCD digits
//   - bcd_step  : single-digit BCD increment with wrap and carry-out
// -----------------------------------------------------------------------------
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [3:0] DIG_MAX_9 = 4'd9;
    localparam logic [3:0] DIG_MAX_5 = 4'd5;

    // Returns {carry_out, next_digit}. Only steps when carry_in is set.
    // Uses >= so an out-of-range digit can only ever fall back to 0.
    function automatic logic [4:0] bcd_step(input logic [3:0] digit,
                                            input logic [3:0] max_val,
                                            input logic       carry_in);
        logic [4:0] result;
        if (!carry_in) begin
            result = {1'b0, digit};
        end else if (digit >= max_val) begin
            result = {1'b1, 4'd0};
        end else begin
            result = {1'b0, digit + 4'd1};
        end
        return result;
    endfunction

endpackage

// File: rtl/stopwatch_bcd_ctrl_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Conditions one raw active-low push-button.
//   clk   : system clock
//   rst   : asynchronous active-low reset
//   key_n : raw button level, active-low, asynchronous to clk
//   press : one-cycle pulse on each accepted press (debounced 1->0)
// The debounced level only follows the synchronized input after DEB_CYCLES
// consecutive disagreeing cycles; any agreeing cycle restarts the count.
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_deb;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_deb   <= 1'b1;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                // Level accepted; only the falling (press) direction is an event.
                r_deb   <= r_sync2;
                r_cnt   <= '0;
                r_press <= ~r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign press = r_press;

endmodule

// File: rtl/stopwatch_bcd_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_bcd_ctrl
// Button conditioning, start/pause/clear FSM, tenths prescaler and an M:SS.t
// BCD counter feeding the 7-segment decoders.
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   key_ss_n   : raw start/stop button, active-low
//   key_clr_n  : raw clear button, active-low
//   dig_t      : tenths digit        (0-9)
//   dig_s0     : seconds ones digit  (0-9)
//   dig_s1     : seconds tens digit  (0-5)
//   dig_m      : minutes digit       (0-9)
//   running    : high while in RUN
//   tick       : one-cycle pulse on each count advance
//   wrap       : one-cycle pulse on the 9:59.9 -> 0:00.0 rollover
//   dbg_state  : current FSM state (debug observation)
//   dbg_presc  : current prescaler value (debug observation)
// CLK_HZ must be an integer multiple of TICK_HZ.
// -----------------------------------------------------------------------------
module stopwatch_bcd_ctrl
    import stopwatch_pkg::*;
#(
    parameter  int CLK_HZ     = 50000000,
    parameter  int TICK_HZ    = 10,
    parameter  int DEB_CYCLES = 1000000,
    localparam int DIV        = CLK_HZ / TICK_HZ,
    localparam int PW         = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_ss_n,
    input  logic          key_clr_n,
    output logic [3:0]    dig_t,
    output logic [3:0]    dig_s0,
    output logic [3:0]    dig_s1,
    output logic [3:0]    dig_m,
    output logic          running,
    output logic          tick,
    output logic          wrap,
    output logic [1:0]    dbg_state,
    output logic [PW-1:0] dbg_presc
);

    localparam logic [PW-1:0] PRESC_TC = PW'(DIV - 1);

    logic          w_ss_evt;
    logic          w_clr_evt;
    logic          w_tc;
    logic [4:0]    w_t_step;
    logic [4:0]    w_s0_step;
    logic [4:0]    w_s1_step;
    logic [4:0]    w_m_step;

    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic [3:0]    r_t;
    logic [3:0]    r_s0;
    logic [3:0]    r_s1;
    logic [3:0]    r_m;
    logic          r_running;
    logic          r_tick;
    logic          r_wrap;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ss (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_ss_n),
        .press (w_ss_evt)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_clr_n),
        .press (w_clr_evt)
    );

    // Prescaler terminal count; only meaningful while RUN.
    assign w_tc = (r_presc >= PRESC_TC);

    // BCD cascade: each stage steps only when every lower stage wraps.
    always_comb begin
        w_t_step  = bcd_step(r_t,  DIG_MAX_9, 1'b1);
        w_s0_step = bcd_step(r_s0, DIG_MAX_9, w_t_step[4]);
        w_s1_step = bcd_step(r_s1, DIG_MAX_5, w_s0_step[4]);
        w_m_step  = bcd_step(r_m,  DIG_MAX_9, w_s1_step[4]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_presc   <= '0;
            r_t       <= '0;
            r_s0      <= '0;
            r_s1      <= '0;
            r_m       <= '0;
            r_running <= 1'b0;
            r_tick    <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
            case (r_state)
                IDLE: begin
                    // IDLE holds everything cleared, so a clr here re-clears.
                    r_presc <= '0;
                    r_t     <= '0;
                    r_s0    <= '0;
                    r_s1    <= '0;
                    r_m     <= '0;
                    if (!w_clr_evt && w_ss_evt) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                    end
                end
                RUN: begin
                    // A tick due on the same edge as a stop press is still applied.
                    if (w_tc) begin
                        r_presc <= '0;
                        r_tick  <= 1'b1;
                        r_wrap  <= w_m_step[4];
                        r_t     <= w_t_step[3:0];
                        r_s0    <= w_s0_step[3:0];
                        r_s1    <= w_s1_step[3:0];
                        r_m     <= w_m_step[3:0];
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                    // clr is ignored while running; ss wins over a simultaneous clr.
                    if (w_ss_evt) begin
                        r_state   <= PAUSE;
                        r_running <= 1'b0;
                    end
                end
                PAUSE: begin
                    // Prescaler holds so the partial tenth survives a resume.
                    if (w_clr_evt) begin
                        r_state   <= IDLE;
                        r_running <= 1'b0;
                        r_presc   <= '0;
                        r_t       <= '0;
                        r_s0      <= '0;
                        r_s1      <= '0;
                        r_m       <= '0;
                    end else if (w_ss_evt) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_running <= 1'b0;
                    r_presc   <= '0;
                    r_t       <= '0;
                    r_s0      <= '0;
                    r_s1      <= '0;
                    r_m       <= '0;
                end
            endcase
        end
    end

    assign dig_t     = r_t;
    assign dig_s0    = r_s0;
    assign dig_s1    = r_s1;
    assign dig_m     = r_m;
    assign running   = r_running;
    assign tick      = r_tick;
    assign wrap      = r_wrap;
    assign dbg_state = r_state;
    assign dbg_presc = r_presc;

endmodule

// File: tb/tb_stopwatch_bcd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_bcd_ctrl
// Directed bench for stopwatch_bcd_ctrl with CLK_HZ=100, TICK_HZ=10
// (10 cycles per tick) and DEB_CYCLES=4.
// -----------------------------------------------------------------------------
module tb_stopwatch_bcd_ctrl;
    import stopwatch_pkg::*;

    localparam int CLK_HZ     = 100;
    localparam int TICK_HZ    = 10;
    localparam int DEB_CYCLES = 4;

    // Clock / reset
    logic       clk = 1'b0;
    logic       rst;
    logic       key_ss_n;
    logic       key_clr_n;
    logic [3:0] dig_t;
    logic [3:0] dig_s0;
    logic [3:0] dig_s1;
    logic [3:0] dig_m;
    logic       running;
    logic       tick;
    logic       wrap;
    logic [1:0] dbg_state;
    logic [3:0] dbg_presc;

    logic [15:0] obs_digits;
    assign obs_digits = {dig_m, dig_s1, dig_s0, dig_t};

    always #5 clk = ~clk;

    stopwatch_bcd_ctrl #(
        .CLK_HZ     (CLK_HZ),
        .TICK_HZ    (TICK_HZ),
        .DEB_CYCLES (DEB_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_ss_n  (key_ss_n),
        .key_clr_n (key_clr_n),
        .dig_t     (dig_t),
        .dig_s0    (dig_s0),
        .dig_s1    (dig_s1),
        .dig_m     (dig_m),
        .running   (running),
        .tick      (tick),
        .wrap      (wrap),
        .dbg_state (dbg_state),
        .dbg_presc (dbg_presc)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int tick_seen = 0;   // tick pulses observed since time 0
    int base = 0;        // tick_seen at the last clear

    always @(negedge clk) begin
        if (tick === 1'b1) tick_seen <= tick_seen + 1;
    end

    // Expected display for n tenths since the last clear.
    function automatic logic [15:0] exp_digits(input int n);
        int t;
        int s;
        int m;
        t = n % 10;
        s = (n / 10) % 60;
        m = (n / 600) % 10;
        return {4'(m), 4'(s / 10), 4'(s % 10), 4'(t)};
    endfunction

    // Driver tasks
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic press_key(input bit ss, input bit clr);
        if (ss)  key_ss_n  = 1'b0;
        if (clr) key_clr_n = 1'b0;
        repeat (10) step();
        key_ss_n  = 1'b1;
        key_clr_n = 1'b1;
        repeat (10) step();
    endtask

    task automatic wait_ticks_to(input int target);
        int budget;
        int k;
        budget = (target - (tick_seen - base)) * 10 + 40;
        k = 0;
        while ((tick_seen - base) < target && k < budget) begin
            step();
            k++;
        end
        if ((tick_seen - base) != target) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_ticks: reached %0d ticks, required %0d", tick_seen - base, target);
        end
    endtask

    // Scenarios
    task automatic test_reset();
        int ticks0;
        rst = 1'b1;
        key_ss_n = 1'b1;
        key_clr_n = 1'b1;
        #3 rst = 1'b0;
        repeat (3) step();
        n_tests++;
        if ({obs_digits, running, tick, wrap} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h/%b%b%b required 0000/000", obs_digits, running, tick, wrap);
        end
        n_tests++;
        if (dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d required %0d", dbg_state, IDLE);
        end
        rst = 1'b1;
        ticks0 = tick_seen;
        repeat (200) step();
        n_tests++;
        if (tick_seen != ticks0) begin
            n_fail++;
            $display("FAIL idle_no_tick: got %0d ticks required 0", tick_seen - ticks0);
        end
        n_tests++;
        if ({obs_digits, running, dbg_presc} !== 21'd0) begin
            n_fail++;
            $display("FAIL idle_hold: got %h run=%b presc=%0d required 0000 0 0", obs_digits, running, dbg_presc);
        end
    endtask

    task automatic test_bounce();
        int rises;
        int k;
        logic prev;
        rises = 0;
        prev = running;
        for (int i = 0; i < 16; i++) begin
            key_ss_n = (i % 2 == 1);
            repeat (2) begin
                step();
                if (running && !prev) rises++;
                prev = running;
            end
        end
        n_tests++;
        if (rises != 0 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce_reject: got %0d starts run=%b required 0 0", rises, running);
        end
        key_ss_n = 1'b0;
        k = 0;
        while (running !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        if (running && !prev) rises++;
        prev = running;
        n_tests++;
        if (k > 8) begin
            n_fail++;
            $display("FAIL start_latency: got %0d cycles required <= 8", k);
        end
        for (int i = 0; i < 30; i++) begin
            if (i == 20 - k) key_ss_n = 1'b1;
            step();
            if (running && !prev) rises++;
            prev = running;
        end
        n_tests++;
        if (rises != 1 || running !== 1'b1 || dbg_state !== RUN) begin
            n_fail++;
            $display("FAIL single_event: got %0d starts run=%b state=%0d required 1 1 %0d", rises, running, dbg_state, RUN);
        end
    endtask

    task automatic test_cascade();
        press_key(1'b1, 1'b0);   // RUN -> PAUSE
        press_key(1'b0, 1'b1);   // PAUSE -> IDLE
        base = tick_seen;
        n_tests++;
        if (obs_digits !== 16'h0000 || dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL clear_before_run: got %h state=%0d required 0000 %0d", obs_digits, dbg_state, IDLE);
        end
        press_key(1'b1, 1'b0);   // IDLE -> RUN
        wait_ticks_to(99);
        n_tests++;
        if (obs_digits !== 16'h0099) begin
            n_fail++;
            $display("FAIL cnt_0_09_9: got %h required 0099", obs_digits);
        end
        wait_ticks_to(100);
        n_tests++;
        if (obs_digits !== 16'h0100 || tick !== 1'b1) begin
            n_fail++;
            $display("FAIL carry_s0_s1: got %h tick=%b required 0100 1", obs_digits, tick);
        end
        wait_ticks_to(599);
        n_tests++;
        if (obs_digits !== 16'h0599) begin
            n_fail++;
            $display("FAIL cnt_0_59_9: got %h required 0599", obs_digits);
        end
        wait_ticks_to(600);
        n_tests++;
        if (obs_digits !== 16'h1000 || tick !== 1'b1) begin
            n_fail++;
            $display("FAIL carry_s1_m: got %h tick=%b required 1000 1", obs_digits, tick);
        end
    endtask

    task automatic test_pause_resume();
        int k;
        logic [15:0] held_digits;
        int held_ticks;
        k = 0;
        while (!(running === 1'b1 && dbg_presc === 4'd9) && k < 20) begin
            step();
            k++;
        end
        // Press lands 7 edges later: 9 -> tick(0) -> 1..5 -> 6 on the pausing edge.
        key_ss_n = 1'b0;
        k = 0;
        while (running !== 1'b0 && k < 20) begin
            step();
            k++;
        end
        n_tests++;
        if (dbg_presc !== 4'd6 || dbg_state !== PAUSE) begin
            n_fail++;
            $display("FAIL pause_point: got presc=%0d state=%0d required 6 %0d", dbg_presc, dbg_state, PAUSE);
        end
        held_digits = obs_digits;
        held_ticks = tick_seen;
        repeat (5) step();
        key_ss_n = 1'b1;
        repeat (50) step();
        n_tests++;
        if (obs_digits !== exp_digits(tick_seen - base) || obs_digits !== held_digits
            || dbg_presc !== 4'd6 || tick_seen != held_ticks) begin
            n_fail++;
            $display("FAIL pause_frozen: got %h presc=%0d ticks+%0d required %h 6 +0",
                     obs_digits, dbg_presc, tick_seen - held_ticks, held_digits);
        end
        key_ss_n = 1'b0;
        k = 0;
        while (running !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        k = 0;
        while (k < 20) begin
            step();
            k++;
            if (tick === 1'b1) break;
        end
        n_tests++;
        if (k != 4) begin
            n_fail++;
            $display("FAIL resume_tick: got %0d cycles required 4", k);
        end
        key_ss_n = 1'b1;
        repeat (10) step();
    endtask

    task automatic test_wrap();
        wait_ticks_to(5998);
        n_tests++;
        if (obs_digits !== 16'h9598 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL preload_9_59_8: got %h wrap=%b required 9598 0", obs_digits, wrap);
        end
        wait_ticks_to(5999);
        n_tests++;
        if (obs_digits !== 16'h9599 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL cnt_9_59_9: got %h wrap=%b required 9599 0", obs_digits, wrap);
        end
        wait_ticks_to(6000);
        n_tests++;
        if (obs_digits !== 16'h0000 || wrap !== 1'b1 || tick !== 1'b1) begin
            n_fail++;
            $display("FAIL rollover: got %h wrap=%b tick=%b required 0000 1 1", obs_digits, wrap, tick);
        end
        step();
        n_tests++;
        if (wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_width: got wrap=%b required 0", wrap);
        end
        wait_ticks_to(6001);
        n_tests++;
        if (obs_digits !== 16'h0001 || running !== 1'b1 || wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL after_wrap: got %h run=%b wrap=%b required 0001 1 0", obs_digits, running, wrap);
        end
    endtask

    task automatic test_clear_rules();
        press_key(1'b0, 1'b1);   // ignored while RUN
        n_tests++;
        if (dbg_state !== RUN || running !== 1'b1 || obs_digits !== exp_digits(tick_seen - base)) begin
            n_fail++;
            $display("FAIL clr_in_run: got state=%0d %h required %0d %h",
                     dbg_state, obs_digits, RUN, exp_digits(tick_seen - base));
        end
        press_key(1'b1, 1'b0);
        n_tests++;
        if (dbg_state !== PAUSE || running !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_state: got state=%0d run=%b required %0d 0", dbg_state, running, PAUSE);
        end
        press_key(1'b0, 1'b1);
        base = tick_seen;
        n_tests++;
        if (dbg_state !== IDLE || obs_digits !== 16'h0000 || dbg_presc !== 4'd0 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_in_pause: got state=%0d %h presc=%0d required %0d 0000 0",
                     dbg_state, obs_digits, dbg_presc, IDLE);
        end
        press_key(1'b1, 1'b0);
        repeat (25) step();
        press_key(1'b1, 1'b0);
        n_tests++;
        if (dbg_state !== PAUSE || obs_digits !== exp_digits(tick_seen - base) || obs_digits === 16'h0000) begin
            n_fail++;
            $display("FAIL pause_with_count: got state=%0d %h required %0d %h",
                     dbg_state, obs_digits, PAUSE, exp_digits(tick_seen - base));
        end
        press_key(1'b1, 1'b1);
        base = tick_seen;
        n_tests++;
        if (dbg_state !== IDLE || obs_digits !== 16'h0000 || dbg_presc !== 4'd0) begin
            n_fail++;
            $display("FAIL both_in_pause: got state=%0d %h presc=%0d required %0d 0000 0",
                     dbg_state, obs_digits, dbg_presc, IDLE);
        end
        press_key(1'b1, 1'b1);
        n_tests++;
        if (dbg_state !== IDLE || running !== 1'b0) begin
            n_fail++;
            $display("FAIL both_in_idle: got state=%0d run=%b required %0d 0", dbg_state, running, IDLE);
        end
    endtask

    task automatic test_async_reset();
        int ticks0;
        press_key(1'b1, 1'b0);
        base = tick_seen;
        repeat (34) step();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if ({obs_digits, running, tick, wrap} !== 19'd0 || dbg_state !== IDLE || dbg_presc !== 4'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %h run=%b state=%0d presc=%0d required 0000 0 %0d 0",
                     obs_digits, running, dbg_state, dbg_presc, IDLE);
        end
        step();
        rst = 1'b1;
        ticks0 = tick_seen;
        repeat (30) step();
        n_tests++;
        if (running !== 1'b0 || obs_digits !== 16'h0000 || tick_seen != ticks0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got run=%b %h ticks+%0d required 0 0000 +0",
                     running, obs_digits, tick_seen - ticks0);
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_cascade();
        test_pause_resume();
        test_wrap();
        test_clear_rules();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
